// File: rtl/demux_1to2_stream_if.sv
// Handshake bundle for the 1:2 stream demux: one producer side and two consumer lanes.
// The slave modport is the demux's view; the master modport is the view of whatever drives it.
interface demux_1to2_stream_if #(
    parameter int n = 8
);
    logic [n-1:0] d;
    logic         sel;
    logic         in_valid;
    logic         in_ready;
    logic [n-1:0] q0;
    logic         q0_valid;
    logic         q0_ready;
    logic [n-1:0] q1;
    logic         q1_valid;
    logic         q1_ready;

    modport master (
        output d, sel, in_valid, q0_ready, q1_ready,
        input  in_ready, q0, q0_valid, q1, q1_valid
    );

    modport slave (
        input  d, sel, in_valid, q0_ready, q1_ready,
        output in_ready, q0, q0_valid, q1, q1_valid
    );
endinterface

// File: rtl/demux_1to2_stream.sv
// Registered 1:2 valid/ready demux: each lane is a one-deep EMPTY/FULL output register.
// Optional drain counters cnt0/cnt1 are built when DEMUX_1TO2_CNT_EN is defined.
module demux_1to2_stream #(
    parameter int n = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    demux_1to2_stream_if.slave  bus
`ifdef DEMUX_1TO2_CNT_EN
    ,
    output logic [15:0]         cnt0,
    output logic [15:0]         cnt1
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } lane_state_t;

    lane_state_t  state_r      [2];
    lane_state_t  state_next_s [2];
    logic [n-1:0] data_r       [2];
    logic [1:0]   valid_s;
    logic [1:0]   lane_ready_s;
    logic [1:0]   load_s;
    logic [1:0]   drain_s;
    logic         in_ready_s;

    assign valid_s      = {state_r[1] == FULL, state_r[0] == FULL};
    assign lane_ready_s = {bus.q1_ready, bus.q0_ready};

    // Acceptance looks only at the selected lane, so a stalled lane never blocks the other
    always_comb begin
        in_ready_s = en && rst_n && (!valid_s[bus.sel] || lane_ready_s[bus.sel]);
        load_s     = {bus.in_valid && in_ready_s && bus.sel,
                      bus.in_valid && in_ready_s && !bus.sel};
        drain_s    = valid_s & lane_ready_s;
        for (int k = 0; k < 2; k++) begin
            state_next_s[k] = state_r[k];
            case (state_r[k])
                EMPTY: begin
                    if (load_s[k]) state_next_s[k] = FULL;
                    else           state_next_s[k] = EMPTY;
                end
                FULL: begin
                    if (drain_s[k] && !load_s[k]) state_next_s[k] = EMPTY;
                    else                          state_next_s[k] = FULL;
                end
                default: state_next_s[k] = EMPTY;
            endcase
        end
    end

    // Lane state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) state_r[k] <= EMPTY;
        end else begin
            for (int k = 0; k < 2; k++) state_r[k] <= state_next_s[k];
        end
    end

    // Lane data registers keep their last word after a drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) data_r[k] <= {n{1'b0}};
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (load_s[k]) data_r[k] <= bus.d;
            end
        end
    end

    assign bus.in_ready = in_ready_s;
    assign bus.q0       = data_r[0];
    assign bus.q0_valid = valid_s[0];
    assign bus.q1       = data_r[1];
    assign bus.q1_valid = valid_s[1];

`ifdef DEMUX_1TO2_CNT_EN
    logic [15:0] cnt_r [2];

    // Per-lane completed-drain counters, wrapping at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) cnt_r[k] <= 16'd0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (drain_s[k]) cnt_r[k] <= cnt_r[k] + 16'd1;
            end
        end
    end

    assign cnt0 = cnt_r[0];
    assign cnt1 = cnt_r[1];
`endif

endmodule

// File: tb/tb_demux_1to2_stream.sv
// Directed bench for demux_1to2_stream: reset, routing, backpressure, throughput, enable gating,
// and the drain counters when DEMUX_1TO2_CNT_EN is defined.
module tb_demux_1to2_stream;

    logic clk;
    logic rst_n;
    logic en;
`ifdef DEMUX_1TO2_CNT_EN
    logic [15:0] cnt0;
    logic [15:0] cnt1;
`endif

    int tests_run;
    int tests_failed;

    demux_1to2_stream_if #(.n(8)) bus ();

    demux_1to2_stream #(.n(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .bus   (bus)
`ifdef DEMUX_1TO2_CNT_EN
        ,
        .cnt0  (cnt0),
        .cnt1  (cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests_run = tests_run + 1;
        if (obs !== expv) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        en           = 1'b1;
        bus.in_valid = 1'b1;
        bus.d        = 8'hFF;
        bus.sel      = 1'b0;
        bus.q0_ready = 1'b0;
        bus.q1_ready = 1'b0;
        repeat (2) step();
        check_val("rst_q0", {24'd0, bus.q0}, 32'h00);
        check_val("rst_q0_valid", {31'd0, bus.q0_valid}, 32'd0);
        check_val("rst_q1_valid", {31'd0, bus.q1_valid}, 32'd0);
        check_val("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);

        // Fill lane 0, then assert reset between edges
        rst_n        = 1'b1;
        bus.d        = 8'hA5;
        step();
        check_val("pre_q0", {24'd0, bus.q0}, 32'hA5);
        check_val("pre_q0_valid", {31'd0, bus.q0_valid}, 32'd1);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_q0", {24'd0, bus.q0}, 32'h00);
        check_val("async_q0_valid", {31'd0, bus.q0_valid}, 32'd0);
        check_val("async_q1_valid", {31'd0, bus.q1_valid}, 32'd0);
        step();
        rst_n = 1'b1;

        // Pass-through
        bus.in_valid = 1'b1;
        bus.d        = 8'hA5;
        bus.sel      = 1'b0;
        bus.q0_ready = 1'b1;
        #1;
        check_val("pt_in_ready", {31'd0, bus.in_ready}, 32'd1);
        step();
        check_val("pt_q0", {24'd0, bus.q0}, 32'hA5);
        check_val("pt_q0_valid", {31'd0, bus.q0_valid}, 32'd1);
        check_val("pt_q1_valid", {31'd0, bus.q1_valid}, 32'd0);

        // Routing: 0x3C to lane 1, then 0xC3 to lane 0
        bus.q1_ready = 1'b1;
        bus.d        = 8'h3C;
        bus.sel      = 1'b1;
        step();
        check_val("rt1_q1", {24'd0, bus.q1}, 32'h3C);
        check_val("rt1_q1_valid", {31'd0, bus.q1_valid}, 32'd1);
        check_val("rt1_q0_valid", {31'd0, bus.q0_valid}, 32'd0);
        bus.d   = 8'hC3;
        bus.sel = 1'b0;
        step();
        check_val("rt2_q0", {24'd0, bus.q0}, 32'hC3);
        check_val("rt2_q0_valid", {31'd0, bus.q0_valid}, 32'd1);
        check_val("rt2_q1_valid", {31'd0, bus.q1_valid}, 32'd0);
        check_val("rt2_q1_hold", {24'd0, bus.q1}, 32'h3C);
        bus.in_valid = 1'b0;
        step();
        check_val("rt3_q0_valid", {31'd0, bus.q0_valid}, 32'd0);
        check_val("rt3_q0_kept", {24'd0, bus.q0}, 32'hC3);

        // Backpressure on lane 0 must not block lane 1
        bus.q0_ready = 1'b0;
        bus.q1_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.d        = 8'h11;
        bus.sel      = 1'b0;
        step();
        check_val("bp_fill_q0", {24'd0, bus.q0}, 32'h11);
        bus.d = 8'h22;
        #1;
        check_val("bp_in_ready_l0", {31'd0, bus.in_ready}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check_val("bp_hold_q0", {24'd0, bus.q0}, 32'h11);
            check_val("bp_hold_q0_valid", {31'd0, bus.q0_valid}, 32'd1);
        end
        bus.d   = 8'h33;
        bus.sel = 1'b1;
        #1;
        check_val("bp_in_ready_l1", {31'd0, bus.in_ready}, 32'd1);
        step();
        check_val("bp_q1", {24'd0, bus.q1}, 32'h33);
        check_val("bp_q1_valid", {31'd0, bus.q1_valid}, 32'd1);
        check_val("bp_q0_still", {24'd0, bus.q0}, 32'h11);
        bus.in_valid = 1'b0;
        bus.q0_ready = 1'b1;
        bus.q1_ready = 1'b1;
        step();
        check_val("bp_q0_drained", {31'd0, bus.q0_valid}, 32'd0);
        check_val("bp_q1_drained", {31'd0, bus.q1_valid}, 32'd0);

        // Full throughput on lane 0
        bus.in_valid = 1'b1;
        bus.sel      = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.d = 8'(i);
            #1;
            check_val("tp_in_ready", {31'd0, bus.in_ready}, 32'd1);
            step();
            check_val("tp_q0", {24'd0, bus.q0}, 32'(i));
            check_val("tp_q0_valid", {31'd0, bus.q0_valid}, 32'd1);
        end
        bus.in_valid = 1'b0;
        step();
        check_val("tp_end_valid", {31'd0, bus.q0_valid}, 32'd0);

        // Enable gating: lane 1 drains while nothing new is accepted
        bus.in_valid = 1'b1;
        bus.sel      = 1'b1;
        bus.d        = 8'h55;
        bus.q1_ready = 1'b0;
        step();
        check_val("en_fill_q1", {24'd0, bus.q1}, 32'h55);
        en           = 1'b0;
        bus.d        = 8'h66;
        bus.q1_ready = 1'b1;
        #1;
        check_val("en_in_ready", {31'd0, bus.in_ready}, 32'd0);
        step();
        check_val("en_q1_valid", {31'd0, bus.q1_valid}, 32'd0);
        check_val("en_q1_val", {24'd0, bus.q1}, 32'h55);
        step();
        check_val("en_q1_valid2", {31'd0, bus.q1_valid}, 32'd0);
        check_val("en_q1_no66", {24'd0, bus.q1}, 32'h55);
        en           = 1'b1;
        bus.in_valid = 1'b0;
        step();

`ifdef DEMUX_1TO2_CNT_EN
        // Counters: fresh reset, 3 drains on lane 0 and 1 on lane 1
        rst_n = 1'b0;
        #1;
        check_val("cnt_rst0", {16'd0, cnt0}, 32'd0);
        step();
        rst_n        = 1'b1;
        bus.q0_ready = 1'b1;
        bus.q1_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.sel      = 1'b0;
        repeat (3) step();
        bus.sel = 1'b1;
        step();
        bus.in_valid = 1'b0;
        repeat (2) step();
        check_val("cnt0_3", {16'd0, cnt0}, 32'd3);
        check_val("cnt1_1", {16'd0, cnt1}, 32'd1);
        bus.in_valid = 1'b1;
        bus.sel      = 1'b0;
        repeat (65532) step();
        bus.in_valid = 1'b0;
        step();
        check_val("cnt0_max", {16'd0, cnt0}, 32'h0000FFFF);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        check_val("cnt0_wrap", {16'd0, cnt0}, 32'h00000000);
        check_val("cnt1_keep", {16'd0, cnt1}, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/demux_1to2_stream.md
Name: demux_1to2_stream

Overview:
- Registered 1:2 demultiplexer with valid/ready handshakes. It is the routing counterpart of the 2:1 mux.
- Steers each accepted n-bit word on d to lane q0 or q1, selected by sel.
- Each lane holds the word in a one-deep output register until the downstream consumer takes it.
- Sits between one producer and two consumers, e.g. fanning a datapath stream out to two execution units.

Parameters:
- n, 8, data width in bits of d, q0 and q1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  global enable; when 0 no new word is accepted.
- d  input  n  input data word.
- sel  input  1  lane select, qualified by in_valid: 0 routes to q0, 1 routes to q1.
- in_valid  input  1  producer has a word on d/sel.
- in_ready  output  1  block accepts the word this cycle.
- q0  output  n  lane 0 data.
- q0_valid  output  1  lane 0 register holds a word.
- q0_ready  input  1  lane 0 consumer takes the word.
- q1  output  n  lane 1 data.
- q1_valid  output  1  lane 1 register holds a word.
- q1_ready  input  1  lane 1 consumer takes the word.

Behaviour:
- Reset (rst_n=0, asynchronous, any cycle):
  - q0, q1 = 0; q0_valid = q1_valid = 0.
  - Any buffered words are discarded.
  - in_ready = 0 while rst_n = 0.
- Each lane is a two-state FSM:
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on drain without a same-cycle load.
  - FULL -> FULL on drain plus load.
- Drain, lane k: qk_valid && qk_ready at a rising edge; the consumer has taken qk.
- Load, lane k: in_valid && in_ready && sel==k at a rising edge; qk <= d and qk_valid <= 1 next cycle.
- Acceptance rule, combinational:
  - in_ready = en && rst_n && (!q[sel]_valid || q[sel]_ready).
  - in_ready depends only on the selected lane. A full, stalled unselected lane never blocks traffic to the other lane.
- Latency: a word accepted at edge t appears on qk with qk_valid=1 after edge t (one cycle).
- Throughput: one word per cycle per lane when the consumer holds ready high.
- Simultaneous drain and load on the same lane: the old word is consumed and the new word is loaded; qk_valid stays 1.
- Loading one lane while draining the other is legal and independent.
- Producer side:
  - Must hold d/sel stable while in_valid=1 && in_ready=0.
  - The block does not latch anything without a handshake.
- en=0:
  - in_ready=0, so no loads occur.
  - Lanes continue to drain normally.
  - en does not affect q0/q1 contents.
- Holding stability:
  - qk and qk_valid stay constant while qk_valid=1 && qk_ready=0.
  - qk is not cleared on drain; it keeps its last value, with qk_valid=0.
- No combinational path from qk_ready to qk or qk_valid. The only comb path is qk_ready to in_ready.

Optional Feature:
- Macro: DEMUX_1TO2_CNT_EN.
- When defined, adds ports cnt0 and cnt1, each output, 16 bits.
  - Each counts completed drains (qk_valid && qk_ready) on its lane.
  - Reset value 0.
  - Wraps 0xFFFF -> 0x0000.
  - Increments one cycle after the drain edge.
- When undefined, the ports and counters do not exist. Core behaviour is identical in both builds.

Test Plan:
- Reset and pass-through:
  - Assert rst_n=0 mid-stream with q0_valid=1 -> q0=0x00, q0_valid=0, q1_valid=0 immediately (no clock edge required).
  - After release, en=1, in_valid=1, d=0xA5, sel=0, q0_ready=1 -> next cycle q0=0xA5, q0_valid=1, q1_valid=0.
- Routing:
  - Send 0x3C with sel=1, then 0xC3 with sel=0, on consecutive cycles with both readies high.
  - Required: q1=0x3C valid in cycle 1; q0=0xC3 valid in cycle 2; no word on the wrong lane.
- Backpressure isolation:
  - Fill lane 0 with 0x11, q0_ready=0.
  - Offer 0x22 sel=0 -> in_ready=0, and q0 stays 0x11 for 5 cycles.
  - Offer 0x33 sel=1 -> in_ready=1, and q1=0x33 next cycle.
- Full throughput:
  - q0_ready=1, stream 0x00..0x0F with sel=0 on every cycle -> in_ready is held 1 and q0 shows 0x00..0x0F on consecutive cycles, with q0_valid never dropping.
- Enable gating:
  - Lane 1 full with 0x55, q1_ready=1, en=0, in_valid=1, d=0x66 -> in_ready=0, lane 1 drains (q1_valid=0 next cycle), 0x66 never appears.
- Counter build (DEMUX_1TO2_CNT_EN):
  - Drain 3 words on lane 0 and 1 word on lane 1 -> cnt0=3, cnt1=1.
  - Preload cnt0 to 0xFFFF via 65535 drains, then one more drain -> cnt0=0x0000.
